mmu_seq_ctrl: RTL and testbench

Sequencer for the systolic MMU array of multiply-accumulate PEs.
- Per job, it first preloads one weight tile into the array through the top-row weight-write chain.
- It then streams a configurable number of input vectors into the left column, with a per-row one-cycle skew.
- It then drains the partial sums out of the bottom row.
- It drives the read ports of the weight and input buffers and gives a start/busy/done handshake to the layer controller.

---
 rtl/mmu_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_mmu_seq_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mmu_seq_ctrl.sv
// Job sequencer for the systolic MMU array: weight preload, skewed input streaming, psum drain.
// Optional macro MMU_SEQ_CTRL_WREUSE_EN adds a w_reuse input that skips the weight preload.
module mmu_seq_ctrl #(
    parameter int ARRAY_DIM  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [LEN_WIDTH-1:0]  in_len,
`ifdef MMU_SEQ_CTRL_WREUSE_EN
    input  logic                  w_reuse,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] w_rd_addr,
    output logic                  w_wen,
    output logic                  in_rd_en,
    output logic [ADDR_WIDTH-1:0] in_rd_addr,
    output logic [ARRAY_DIM-1:0]  en
);

    // One counter serves all phases; wide enough for both in_len and the drain window.
    localparam int DW    = $clog2(2 * ARRAY_DIM + 1);
    localparam int CNT_W = (LEN_WIDTH > DW) ? LEN_WIDTH : DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ARRAY_DIM-1:0]  skew_q, skew_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_base_d  = w_base_q;
        in_base_d = in_base_q;
        len_d     = len_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    w_base_d  = w_base;
                    in_base_d = in_base;
                    len_d     = in_len;
`ifdef MMU_SEQ_CTRL_WREUSE_EN
                    if (w_reuse)
                        state_d = (in_len == '0) ? S_DONE : S_STREAM;
                    else
                        state_d = S_WLOAD;
`else
                    state_d = S_WLOAD;
`endif
                end
            end
            S_WLOAD: begin
                // ARRAY_DIM reads plus one trailing cycle for the delayed write enable
                if (cnt_q == CNT_W'(ARRAY_DIM)) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? S_DONE : S_STREAM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (cnt_q + 1'b1 == CNT_W'(len_q)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(2 * ARRAY_DIM - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_en    = (state_q == S_WLOAD) && (cnt_q < CNT_W'(ARRAY_DIM));
        w_wen      = (state_q == S_WLOAD) && (cnt_q != '0);
        w_rd_addr  = w_rd_en ? (w_base_q + ADDR_WIDTH'(cnt_q)) : '0;
        in_rd_en   = (state_q == S_STREAM);
        in_rd_addr = in_rd_en ? (in_base_q + ADDR_WIDTH'(cnt_q)) : '0;
        busy       = (state_q == S_WLOAD) || (state_q == S_STREAM) || (state_q == S_DRAIN);
        done       = (state_q == S_DONE);
        // bit 0 is in_rd_en delayed once; each further row adds one cycle of skew
        skew_d     = {skew_q[ARRAY_DIM-2:0], in_rd_en};
        en         = skew_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            w_base_q  <= '0;
            in_base_q <= '0;
            len_q     <= '0;
            skew_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_base_q  <= w_base_d;
            in_base_q <= in_base_d;
            len_q     <= len_d;
            skew_q    <= skew_d;
        end
    end

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Self-checking bench for mmu_seq_ctrl: job table, per-cycle expected outputs via scoreboard queue.
module tb_mmu_seq_ctrl;

    localparam int D  = 4;
    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] w_base, in_base;
    logic [LW-1:0] in_len;
    logic          w_reuse;
    logic          busy, done, w_rd_en, w_wen, in_rd_en;
    logic [AW-1:0] w_rd_addr, in_rd_addr;
    logic [D-1:0]  en;

    always #5 clk = ~clk;

    mmu_seq_ctrl #(.ARRAY_DIM(D), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .w_base     (w_base),
        .in_base    (in_base),
        .in_len     (in_len),
`ifdef MMU_SEQ_CTRL_WREUSE_EN
        .w_reuse    (w_reuse),
`endif
        .busy       (busy),
        .done       (done),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_wen      (w_wen),
        .in_rd_en   (in_rd_en),
        .in_rd_addr (in_rd_addr),
        .en         (en)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          w_rd_en;
        logic [AW-1:0] w_rd_addr;
        logic          w_wen;
        logic          in_rd_en;
        logic [AW-1:0] in_rd_addr;
        logic [D-1:0]  en;
    } obs_t;

    typedef struct {
        logic [AW-1:0] w_base;
        logic [AW-1:0] in_base;
        logic [LW-1:0] len;
        bit            reuse;
        int            restart1;
        int            restart2;
        int            rst_k;
        int            exp_done;
    } job_t;

    int   checks = 0;
    int   errors = 0;
    obs_t sb_q[$];
    job_t jobs[$];

    function automatic obs_t sample();
        obs_t o;
        o.busy       = busy;
        o.done       = done;
        o.w_rd_en    = w_rd_en;
        o.w_rd_addr  = w_rd_addr;
        o.w_wen      = w_wen;
        o.in_rd_en   = in_rd_en;
        o.in_rd_addr = in_rd_addr;
        o.en         = en;
        return o;
    endfunction

    // Done cycle from the phase lengths: WLOAD D+1, STREAM len, DRAIN 2D, then DONE.
    function automatic int done_cycle(job_t j);
        int wl = j.reuse ? 0 : D + 1;
        int ln = int'(j.len);
        return (ln == 0) ? wl + 1 : wl + 1 + ln + 2 * D;
    endfunction

    function automatic obs_t expect_at(job_t j, int k);
        obs_t o  = '0;
        int   wl = j.reuse ? 0 : D + 1;
        int   s0 = wl + 1;
        int   ln = int'(j.len);
        int   dc = done_cycle(j);
        if (!j.reuse && k >= 1 && k <= D) begin
            o.w_rd_en   = 1'b1;
            o.w_rd_addr = j.w_base + AW'(k - 1);
        end
        if (!j.reuse && k >= 2 && k <= D + 1) o.w_wen = 1'b1;
        if (ln > 0 && k >= s0 && k < s0 + ln) begin
            o.in_rd_en   = 1'b1;
            o.in_rd_addr = j.in_base + AW'(k - s0);
        end
        for (int r = 0; r < D; r++)
            if (ln > 0 && k >= s0 + 1 + r && k <= s0 + ln + r) o.en[r] = 1'b1;
        o.busy = (k >= 1) && (k < dc);
        o.done = (k == dc);
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic run_job(job_t j, int id);
        int   dc   = done_cycle(j);
        int   seen = -1;
        obs_t e;
        sb_q.delete();
        for (int k = 1; k <= dc + 1; k++) sb_q.push_back(expect_at(j, k));
        w_base  = j.w_base;
        in_base = j.in_base;
        in_len  = j.len;
        w_reuse = j.reuse;
        start   = 1'b1;
        for (int k = 1; k <= dc + 1; k++) begin
            step();
            start = 1'b0;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL job%0d_queue_empty cycle %0d", id, k);
                return;
            end
            e = sb_q.pop_front();
            check($sformatf("job%0d_cycle%0d", id, k), sample(), e);
            if (done === 1'b1 && seen < 0) seen = k;
            if (k == j.rst_k) begin
                rstn = 1'b0;
                #1;
                check($sformatf("job%0d_reset_now", id), sample(), '0);
                for (int c = 0; c < 3; c++) begin
                    step();
                    check($sformatf("job%0d_in_reset%0d", id, c), sample(), '0);
                end
                rstn = 1'b1;
                for (int c = 0; c < 12; c++) begin
                    step();
                    check($sformatf("job%0d_after_reset%0d", id, c), sample(), '0);
                end
                sb_q.delete();
                return;
            end
            if (k == j.restart1 || k == j.restart2) begin
                start   = 1'b1;
                w_base  = 10'h2AA;
                in_base = 10'h155;
                in_len  = 10'd7;
            end
        end
        checks++;
        if (seen != j.exp_done) begin
            errors++;
            $display("FAIL job%0d_done_cycle got=%0d exp=%0d", id, seen, j.exp_done);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        start   = 1'b0;
        w_base  = '0;
        in_base = '0;
        in_len  = '0;
        w_reuse = 1'b0;

        //              w_base  in_base  len     reuse r1  r2  rst  done
        jobs.push_back('{10'h010, 10'h100, 10'd3,    0, 0,  0,  0,  17});
        jobs.push_back('{10'h020, 10'h200, 10'd0,    0, 0,  0,  0,  6});
        jobs.push_back('{10'h000, 10'h3FE, 10'd4,    0, 0,  0,  0,  18});
        jobs.push_back('{10'h010, 10'h100, 10'd3,    0, 7,  17, 0,  17});
        jobs.push_back('{10'h010, 10'h100, 10'd3,    0, 0,  0,  0,  17});
        jobs.push_back('{10'h010, 10'h100, 10'd3,    0, 0,  0,  7,  -1});
        jobs.push_back('{10'h010, 10'h100, 10'd3,    0, 0,  0,  0,  17});
        jobs.push_back('{10'h3FE, 10'h005, 10'd1023, 0, 0,  0,  0,  1037});
`ifdef MMU_SEQ_CTRL_WREUSE_EN
        jobs.push_back('{10'h040, 10'h080, 10'd2,    1, 0,  0,  0,  11});
        jobs.push_back('{10'h040, 10'h080, 10'd0,    1, 0,  0,  0,  1});
`endif

        repeat (3) step();
        check("reset_state", sample(), '0);
        rstn = 1'b1;
        step();
        check("idle_after_release", sample(), '0);

        foreach (jobs[i]) run_job(jobs[i], i);

        step();
        check("final_idle", sample(), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
